mem_io_responder: RTL

MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

---
 rtl/mem_io_pkg.sv | 37 +++
 rtl/mem_io_responder_if.sv | 27 ++
 rtl/mem_io_responder_tx_queue.sv | 61 ++++++
 rtl/mem_io_responder.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/mem_io_pkg.sv
// Shared constants, address-decode targets and the IO-window decode helper.
package mem_io_pkg;
  localparam int BYTE_W = 8;
  localparam int DEC_AW = 18;
  localparam int CNT_W  = 32;

  localparam logic [DEC_AW-1:0] IO_BASE      = 18'h30000;
  localparam logic [DEC_AW-1:0] IO_UART      = 18'h00000;
  localparam logic [DEC_AW-1:0] IO_CLK       = 18'h00004;
  localparam logic [DEC_AW-1:0] IO_UART_ADDR = IO_BASE | IO_UART;
  localparam logic [DEC_AW-1:0] IO_CLK_ADDR  = IO_BASE | IO_CLK;

  typedef enum logic [2:0] {
    TGT_RAM   = 3'd0,
    TGT_UART  = 3'd1,
    TGT_CLK0  = 3'd2,
    TGT_CLKHI = 3'd3,
    TGT_NONE  = 3'd4
  } io_tgt_e;

  // TGT_CLKHI covers the three upper snapshot bytes following the counter address.
  function automatic io_tgt_e decode_io(input logic [DEC_AW-1:0] a);
    io_tgt_e t;
    if (a[DEC_AW-1:DEC_AW-2] != 2'b11) begin
      t = TGT_RAM;
    end else if (a == IO_UART_ADDR) begin
      t = TGT_UART;
    end else if (a == IO_CLK_ADDR) begin
      t = TGT_CLK0;
    end else if (a[DEC_AW-1:2] == IO_CLK_ADDR[DEC_AW-1:2]) begin
      t = TGT_CLKHI;
    end else begin
      t = TGT_NONE;
    end
    return t;
  endfunction
endpackage

// File: rtl/mem_io_responder_if.sv
// CPU memory bus plus UART transmit/receive streams of the responder.
interface mem_io_responder_if;
  import mem_io_pkg::*;

  logic [31:0]       mem_a;
  logic              mem_wr;
  logic [BYTE_W-1:0] mem_dout;
  logic [BYTE_W-1:0] mem_din;
  logic              io_buffer_full;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_pop;
  logic              prog_stop;

  modport slave (
    input  mem_a, mem_wr, mem_dout, tx_ready, rx_data, rx_valid,
    output mem_din, io_buffer_full, tx_data, tx_valid, rx_pop, prog_stop
  );

  modport master (
    output mem_a, mem_wr, mem_dout, tx_ready, rx_data, rx_valid,
    input  mem_din, io_buffer_full, tx_data, tx_valid, rx_pop, prog_stop
  );
endinterface

// File: rtl/mem_io_responder_tx_queue.sv
// Circular transmit FIFO; a pop frees a slot for a push in the same cycle, even when full.
module tx_queue #(
  parameter int DEPTH = 8,
  parameter int W     = 8,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          push_i,
  input  logic [W-1:0]  push_data_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_o,
  output logic [CW-1:0] count_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_pop_s, do_push_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1'b1);
    end
  endfunction

  always_comb begin
    do_pop_s  = pop_i && (cnt_q != '0);
    do_push_s = push_i && ((cnt_q != CW'(DEPTH)) || do_pop_s);
    rd_ptr_d  = do_pop_s  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d  = do_push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   cnt_d = cnt_q + CW'(1'b1);
      2'b01:   cnt_d = cnt_q - CW'(1'b1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/mem_io_responder.sv
// Memory/IO responder: byte RAM plus UART queue, cycle counter and stop flag in the IO window.
module mem_io_responder
  import mem_io_pkg::*;
#(
  parameter int RAM_AW    = 17,
  parameter int TXQ_DEPTH = 8,
  parameter int FULL_TH   = 6
) (
  input logic               clk_in,
  input logic               rst_in,
  mem_io_responder_if.slave bus
);
  localparam int CW = $clog2(TXQ_DEPTH + 1);

  logic [DEC_AW-1:0] addr_s;
  logic [RAM_AW-1:0] ram_addr_s;
  io_tgt_e           tgt_s;
  logic              rd_s, wr_s, ram_we_s;
  logic              unused_addr_s;

  logic [BYTE_W-1:0] ram_q [2**RAM_AW];
  logic [BYTE_W-1:0] ram_rd_q;

  logic [CNT_W-1:0]  cnt_q, cnt_d, snap_q, snap_d;
  logic              rsp_ram_q, rsp_ram_d, rsp_io_q, rsp_io_d;
  logic [BYTE_W-1:0] io_rdata_q, io_rdata_d, hold_q, hold_d, mem_din_s;
  logic              rx_pop_q, rx_pop_d, prog_stop_q, prog_stop_d;

  logic              push_s, pop_s, tx_valid_s;
  logic [BYTE_W-1:0] push_data_s, head_s;
  logic [CW-1:0]     occ_s;

  assign addr_s        = bus.mem_a[DEC_AW-1:0];
  assign ram_addr_s    = bus.mem_a[RAM_AW-1:0];
  assign unused_addr_s = ^bus.mem_a[31:DEC_AW];
  assign tgt_s         = decode_io(addr_s);
  assign wr_s          = bus.mem_wr;
  assign rd_s          = ~bus.mem_wr;
  assign ram_we_s      = wr_s && (tgt_s == TGT_RAM);

  // Contents deliberately survive reset.
  always_ff @(posedge clk_in) begin
    if (ram_we_s) begin
      ram_q[ram_addr_s] <= bus.mem_dout;
    end
    ram_rd_q <= ram_q[ram_addr_s];
  end

  always_comb begin
    io_rdata_d = '0;
    case (tgt_s)
      TGT_UART: io_rdata_d = bus.rx_valid ? bus.rx_data : 8'h00;
      TGT_CLK0: io_rdata_d = cnt_q[7:0];
      TGT_CLKHI: begin
        case (addr_s[1:0])
          2'd1:    io_rdata_d = snap_q[15:8];
          2'd2:    io_rdata_d = snap_q[23:16];
          2'd3:    io_rdata_d = snap_q[31:24];
          default: io_rdata_d = 8'h00;
        endcase
      end
      default: io_rdata_d = 8'h00;
    endcase
  end

  // mem_din shows a fresh response only after a read, otherwise replays the last value.
  always_comb begin
    mem_din_s = hold_q;
    if (rsp_ram_q) begin
      mem_din_s = ram_rd_q;
    end else if (rsp_io_q) begin
      mem_din_s = io_rdata_q;
    end else begin
      mem_din_s = hold_q;
    end
  end

  always_comb begin
    cnt_d     = cnt_q + CNT_W'(1'b1);
    rsp_ram_d = rd_s && (tgt_s == TGT_RAM);
    rsp_io_d  = rd_s && (tgt_s != TGT_RAM);
    rx_pop_d  = rd_s && (tgt_s == TGT_UART) && bus.rx_valid;
    hold_d    = mem_din_s;
    snap_d    = snap_q;
    if (rd_s && (tgt_s == TGT_CLK0)) begin
      snap_d = cnt_q;
    end else begin
      snap_d = snap_q;
    end
    prog_stop_d = prog_stop_q;
    if (wr_s && (tgt_s == TGT_CLK0)) begin
      prog_stop_d = 1'b1;
    end else begin
      prog_stop_d = prog_stop_q;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q       <= '0;
      snap_q      <= '0;
      rsp_ram_q   <= 1'b0;
      rsp_io_q    <= 1'b0;
      io_rdata_q  <= '0;
      hold_q      <= '0;
      rx_pop_q    <= 1'b0;
      prog_stop_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      snap_q      <= snap_d;
      rsp_ram_q   <= rsp_ram_d;
      rsp_io_q    <= rsp_io_d;
      io_rdata_q  <= io_rdata_d;
      hold_q      <= hold_d;
      rx_pop_q    <= rx_pop_d;
      prog_stop_q <= prog_stop_d;
    end
  end

  // A zero byte to the UART port is a no-op; the stop write queues an explicit 0x00 marker.
  always_comb begin
    push_s      = 1'b0;
    push_data_s = 8'h00;
    if (wr_s && (tgt_s == TGT_UART) && (bus.mem_dout != 8'h00)) begin
      push_s      = 1'b1;
      push_data_s = bus.mem_dout;
    end else if (wr_s && (tgt_s == TGT_CLK0)) begin
      push_s      = 1'b1;
      push_data_s = 8'h00;
    end else begin
      push_s      = 1'b0;
      push_data_s = 8'h00;
    end
  end

  tx_queue #(
    .DEPTH (TXQ_DEPTH),
    .W     (BYTE_W)
  ) u_tx_queue (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .push_i      (push_s),
    .push_data_i (push_data_s),
    .pop_i       (pop_s),
    .head_o      (head_s),
    .count_o     (occ_s)
  );

  assign tx_valid_s         = (occ_s != '0);
  assign pop_s              = tx_valid_s && bus.tx_ready;
  assign bus.tx_valid       = tx_valid_s;
  assign bus.tx_data        = tx_valid_s ? head_s : 8'h00;
  assign bus.io_buffer_full = (occ_s >= CW'(FULL_TH));
  assign bus.mem_din        = mem_din_s;
  assign bus.rx_pop         = rx_pop_q;
  assign bus.prog_stop      = prog_stop_q;
endmodule
